// File: rtl/cart_so_receiver.sv
// Cartridge serial-out frame receiver: start 0, 16 data bits LSB first, trailer 0.
// Define SO_RX_SYNC_EN to pass SI through a two-flop synchronizer (adds 2 cycles of latency).
module cart_so_receiver #(
    parameter logic [15:0] KEY = 16'h28A0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SI,
    output logic [15:0] WORD,
    output logic        VALID,
    output logic        FERR,
    output logic        BUSY,
    output logic        UNLOCK
);

    typedef enum logic [1:0] {IDLE, DATA, TRAIL, GAP} state_t;

    logic        si_s;
    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] data_reg, data_next;
    logic        valid_pend_reg, valid_pend_next;
    logic        ferr_pend_reg, ferr_pend_next;

`ifdef SO_RX_SYNC_EN
    logic [1:0] sync_reg;

    // Reset to 1 so the synchronizer looks like an idle line and cannot fake a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], SI};
        end
    end

    assign si_s = sync_reg[1];
`else
    assign si_s = SI;
`endif

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        data_next       = data_reg;
        valid_pend_next = 1'b0;
        ferr_pend_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!si_s) begin
                    state_next = DATA;
                    cnt_next   = 4'd0;
                end
            end
            DATA: begin
                data_next[cnt_reg] = si_s;
                cnt_next           = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    state_next = TRAIL;
                end
            end
            TRAIL: begin
                if (si_s) begin
                    ferr_pend_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    valid_pend_next = 1'b1;
                    state_next      = GAP;
                end
            end
            GAP: begin
                if (si_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The trailer verdict is held one extra cycle so the pulse lands 18 edges after the start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            data_reg       <= 16'd0;
            valid_pend_reg <= 1'b0;
            ferr_pend_reg  <= 1'b0;
            WORD           <= 16'd0;
            VALID          <= 1'b0;
            FERR           <= 1'b0;
            UNLOCK         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            data_reg       <= data_next;
            valid_pend_reg <= valid_pend_next;
            ferr_pend_reg  <= ferr_pend_next;
            VALID          <= valid_pend_reg;
            FERR           <= ferr_pend_reg;
            if (valid_pend_reg) begin
                WORD <= data_reg;
                if (data_reg == KEY) begin
                    UNLOCK <= 1'b1;
                end
            end
        end
    end

    assign BUSY = (state_reg != IDLE);

endmodule

// File: tb/tb_cart_so_receiver.sv
// Randomized bench for cart_so_receiver: SI streams are parsed by a frame-level model
// and every cycle's VALID/FERR/BUSY/WORD/UNLOCK is compared against it.
module tb_cart_so_receiver;

    localparam logic [15:0] KEY = 16'h28A0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SI  = 1'b1;
    logic [15:0] WORD;
    logic        VALID, FERR, BUSY, UNLOCK;

    int checks = 0;
    int passed = 0;

    bit          stim[$];
    bit          e_valid[], e_ferr[], e_busy[], e_unlock[];
    logic [15:0] e_word[];

    cart_so_receiver #(.KEY(KEY)) dut (
        .CLK(CLK), .RST(RST), .SI(SI), .WORD(WORD),
        .VALID(VALID), .FERR(FERR), .BUSY(BUSY), .UNLOCK(UNLOCK)
    );

    always #5 CLK = ~CLK;

    // Value the receiver logic sees at edge k (synchronizer shows idle 1s first).
    function automatic bit samp(input int k);
`ifdef SO_RX_SYNC_EN
        if (k < 2) return 1'b1;
        return stim[k-2];
`else
        return stim[k];
`endif
    endfunction

    task automatic push_frame(input logic [15:0] d, input bit tr);
        stim.push_back(1'b0);
        for (int i = 0; i < 16; i++) stim.push_back(d[i]);
        stim.push_back(tr);
    endtask

    task automatic push_ones(input int n);
        for (int i = 0; i < n; i++) stim.push_back(1'b1);
    endtask

    // Frame-level reference: walk the sampled line and mark per-edge expectations.
    task automatic build_model();
        int n;
        int k;
        logic [15:0] cur_w;
        bit cur_u;
        bit          upd[];
        logic [15:0] upd_w[];
        n = stim.size();
        e_valid = new[n]; e_ferr = new[n]; e_busy = new[n];
        e_unlock = new[n]; e_word = new[n];
        upd = new[n]; upd_w = new[n];
        for (int e = 0; e < n; e++) begin
            e_valid[e] = 0; e_ferr[e] = 0; e_busy[e] = 0; upd[e] = 0; upd_w[e] = 16'd0;
        end
        k = 0;
        while (k < n) begin
            if (samp(k)) begin
                k++;
            end else if (k + 17 > n - 1) begin
                for (int e = k; e < n; e++) e_busy[e] = 1;
                k = n;
            end else begin
                logic [15:0] d;
                int start;
                start = k;
                d = 16'd0;
                for (int b = 0; b < 16; b++) d[b] = samp(start + 1 + b);
                for (int e = start; e <= start + 16; e++) e_busy[e] = 1;
                if (samp(start + 17)) begin
                    if (start + 18 < n) e_ferr[start + 18] = 1;
                    k = start + 18;
                end else begin
                    if (start + 18 < n) begin
                        e_valid[start + 18] = 1;
                        upd[start + 18] = 1;
                        upd_w[start + 18] = d;
                    end
                    e_busy[start + 17] = 1;
                    k = n;
                    for (int m = start + 18; m < n; m++) begin
                        if (samp(m)) begin
                            k = m + 1;
                            break;
                        end
                        e_busy[m] = 1;
                    end
                end
            end
        end
        cur_w = 16'd0;
        cur_u = 0;
        for (int e = 0; e < n; e++) begin
            if (upd[e]) begin
                cur_w = upd_w[e];
                if (upd_w[e] == KEY) cur_u = 1;
            end
            e_word[e] = cur_w;
            e_unlock[e] = cur_u;
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge CLK);
        RST = 1'b1;
        SI  = 1'b1;
        #1;
        checks++;
        if ({WORD, VALID, FERR, BUSY, UNLOCK} !== 20'd0) begin
            $display("FAIL %s reset outputs: got word=%h valid=%b ferr=%b busy=%b unlock=%b, want all 0",
                     name, WORD, VALID, FERR, BUSY, UNLOCK);
        end else begin
            passed++;
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drive stim cycle by cycle; outputs after edge c-1 are checked at negedge c.
    task automatic run_stream(input string name);
        int n;
        build_model();
        n = stim.size();
        for (int c = 0; c <= n; c++) begin
            @(negedge CLK);
            if (c > 0) begin
                int e;
                e = c - 1;
                checks++;
                if (VALID !== e_valid[e]) $display("FAIL %s valid edge=%0d: got %b want %b", name, e, VALID, e_valid[e]);
                else passed++;
                checks++;
                if (FERR !== e_ferr[e]) $display("FAIL %s ferr edge=%0d: got %b want %b", name, e, FERR, e_ferr[e]);
                else passed++;
                checks++;
                if (BUSY !== e_busy[e]) $display("FAIL %s busy edge=%0d: got %b want %b", name, e, BUSY, e_busy[e]);
                else passed++;
                checks++;
                if (WORD !== e_word[e]) $display("FAIL %s word edge=%0d: got %h want %h", name, e, WORD, e_word[e]);
                else passed++;
                checks++;
                if (UNLOCK !== e_unlock[e]) $display("FAIL %s unlock edge=%0d: got %b want %b", name, e, UNLOCK, e_unlock[e]);
                else passed++;
                if (e_valid[e]) $display("%s: edge %0d frame word=%h unlock=%b", name, e, e_word[e], e_unlock[e]);
                if (e_ferr[e])  $display("%s: edge %0d framing error", name, e);
            end
            SI = (c < n) ? stim[c] : 1'b1;
        end
        stim.delete();
    endtask

    task automatic test_reset();
        apply_reset("reset");
        push_ones(10);
        run_stream("reset_idle");
    endtask

    task automatic test_unlock_frame();
        apply_reset("unlock");
        push_ones(3);
        push_frame(KEY, 1'b0);
        push_ones(10);
        run_stream("unlock_key");
    endtask

    task automatic test_second_frame();
        apply_reset("second");
        push_ones(2);
        push_frame(KEY, 1'b0);
        push_ones(4);
        push_frame(16'h1234, 1'b0);
        push_ones(10);
        run_stream("key_then_1234");
        apply_reset("second_fresh");
        push_ones(2);
        push_frame(16'h1234, 1'b0);
        push_ones(10);
        run_stream("1234_no_unlock");
    endtask

    task automatic test_framing_error();
        apply_reset("ferr");
        push_ones(2);
        push_frame(16'h5A5A, 1'b0);
        push_ones(3);
        push_frame(16'hBEEF, 1'b1);
        push_ones(10);
        run_stream("beef_ferr");
    endtask

    task automatic test_abort();
        apply_reset("abort");
        push_ones(2);
        stim.push_back(1'b0);
        for (int i = 0; i < 8; i++) stim.push_back(KEY[i]);
        run_stream("abort_partial");
        apply_reset("abort_mid");
        push_frame(KEY, 1'b0);
        push_ones(10);
        run_stream("abort_then_key");
    endtask

    task automatic test_stuck_low();
        apply_reset("stuck");
        for (int i = 0; i < 60; i++) stim.push_back(1'b0);
        push_ones(8);
        run_stream("stuck_low");
    endtask

    task automatic test_back_to_back();
        apply_reset("b2b");
        push_frame(16'hC3A5, 1'b1);
        push_frame(16'h0F0F, 1'b0);
        stim.push_back(1'b1);
        push_frame(KEY, 1'b0);
        stim.push_back(1'b1);
        push_frame(16'hFFFF, 1'b0);
        push_ones(8);
        run_stream("back_to_back");
    endtask

    task automatic test_random();
        apply_reset("rand_frames");
        for (int f = 0; f < 10; f++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
            push_frame(d, ($urandom_range(0, 3) == 0));
            for (int g = 0; g < $urandom_range(0, 3); g++) stim.push_back(1'b0);
            push_ones($urandom_range(1, 4));
        end
        push_ones(24);
        run_stream("rand_frames");
        apply_reset("rand_bits");
        for (int i = 0; i < 200; i++) stim.push_back(1'($urandom_range(0, 1)));
        push_ones(24);
        run_stream("rand_bits");
    endtask

    initial begin
        test_reset();
        test_unlock_frame();
        test_second_frame();
        test_framing_error();
        test_abort();
        test_stuck_low();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
